instr_fetch_unit: RTL and testbench

Fetch stage directly downstream of the program-counter register in the multicycle core. Takes the current PC on request, issues one aligned instruction-memory read, and presents the fetched word plus its PC to decode with a valid/ready handshake. On a successful fetch it pulses the PC write-enable with PC+4, so the PC register advances. Detects misaligned PCs, bus errors and memory timeouts and reports a sticky fault to the control FSM.

---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/instr_fetch_unit_timeout_counter.sv | 37 +++
 rtl/instr_fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_unit_pkg;

    localparam int IFU_XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_BUSERR   = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;

endpackage

// File: rtl/instr_fetch_unit_timeout_counter.sv
// Counts WAIT cycles without a response; expire_o flags the cycle whose
// increment would reach TIMEOUT_CYCLES.
module instr_fetch_unit_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one aligned imem read per request, valid/ready hand-off to
// decode, PC+4 write pulse on success, sticky fault on misalign/error/timeout.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int XLEN           = IFU_XLEN,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] pc_i,
    input  logic            fetch_start_i,
    input  logic            flush_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            imem_err_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic            pc_write_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic            fault_o,
    output logic [1:0]      fault_cause_o,
    input  logic            fault_clear_i,
    output fetch_state_e    dbg_state_o
);

    // Handshake: instr_o/instr_pc_o are held stable while instr_valid_o is
    // high; the word transfers on a cycle where instr_valid_o && instr_ready_i.

    fetch_state_e    state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic            valid_q, valid_d;
    logic            pcw_q, pcw_d;
    logic [XLEN-1:0] pcn_q, pcn_d;
    logic            fault_q, fault_d;
    logic [1:0]      cause_q, cause_d;
    logic            drop_q, drop_d;

    logic cnt_clear;
    logic cnt_en;
    logic cnt_expire;
    logic try_issue;

    instr_fetch_unit_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .resetn   (resetn),
        .clear_i  (cnt_clear),
        .enable_i (cnt_en),
        .expire_o (cnt_expire)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        valid_d   = valid_q;
        pcw_d     = 1'b0;
        pcn_d     = pcn_q;
        fault_d   = fault_q;
        cause_d   = cause_q;
        drop_d    = drop_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        try_issue = 1'b0;

        case (state_q)
            ST_IDLE: try_issue = fetch_start_i;
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    req_d  = 1'b0;
                    drop_d = 1'b0;
                    if (imem_err_i) begin
                        fault_d = 1'b1;
                        cause_d = FC_BUSERR;
                        state_d = ST_FAULT;
                    end else if (drop_q || flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        instr_d = imem_rdata_i;
                        ipc_d   = addr_q;
                        valid_d = 1'b1;
                        pcw_d   = 1'b1;
                        pcn_d   = addr_q + XLEN'(4);
                        state_d = ST_HOLD;
                    end
                end else if (cnt_expire) begin
                    req_d   = 1'b0;
                    drop_d  = 1'b0;
                    fault_d = 1'b1;
                    cause_d = FC_TIMEOUT;
                    state_d = ST_FAULT;
                end else begin
                    // A flush never abandons the bus request; it only marks
                    // the eventual response for discard.
                    cnt_en = 1'b1;
                    if (flush_i) begin
                        drop_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (flush_i) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (instr_ready_i) begin
                    valid_d   = 1'b0;
                    state_d   = ST_IDLE;
                    try_issue = fetch_start_i;
                end
            end
            ST_FAULT: begin
                if (fault_clear_i) begin
                    fault_d = 1'b0;
                    cause_d = FC_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (try_issue) begin
            if (pc_i[1:0] == 2'b00) begin
                addr_d    = pc_i;
                req_d     = 1'b1;
                cnt_clear = 1'b1;
                state_d   = ST_WAIT;
            end else begin
                fault_d = 1'b1;
                cause_d = FC_MISALIGN;
                state_d = ST_FAULT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            pcw_q   <= 1'b0;
            pcn_q   <= '0;
            fault_q <= 1'b0;
            cause_q <= FC_NONE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            pcw_q   <= pcw_d;
            pcn_q   <= pcn_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            drop_q  <= drop_d;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = ipc_q;
    assign instr_valid_o = valid_q;
    assign pc_write_o    = pcw_q;
    assign pc_next_o     = pcn_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized fetches
// scored against a transaction-level model of the fetch rules.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] pc_i = '0;
    logic        fetch_start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_err_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic        pc_write_o;
    logic [31:0] pc_next_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;
    logic        fault_clear_i = 1'b0;
    fetch_state_e dbg_state_o;

    int check_cnt = 0;
    int pass_cnt  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .resetn(resetn), .pc_i(pc_i), .fetch_start_i(fetch_start_i),
        .flush_i(flush_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .imem_err_i(imem_err_i), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .pc_write_o(pc_write_o), .pc_next_o(pc_next_o), .fault_o(fault_o),
        .fault_cause_o(fault_cause_o), .fault_clear_i(fault_clear_i),
        .dbg_state_o(dbg_state_o)
    );

    // Driver tasks: inputs change 1ns after the edge, outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fetch(input logic [31:0] pc);
        fetch_start_i = 1'b1;
        pc_i = pc;
        step();
        fetch_start_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        imem_rvalid_i = 1'b1;
        imem_rdata_i = data;
        imem_err_i = err;
        step();
        imem_rvalid_i = 1'b0;
        imem_err_i = 1'b0;
    endtask

    task automatic pulse_clear();
        fault_clear_i = 1'b1;
        step();
        fault_clear_i = 1'b0;
    endtask

    task automatic accept();
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        check_cnt++;
        if ({imem_req_o, imem_addr_o, instr_o, instr_pc_o, instr_valid_o, pc_write_o,
             pc_next_o, fault_o, fault_cause_o} !== '0)
            $display("FAIL reset_outputs req=%b addr=%h instr=%h ipc=%h v=%b pcw=%b pcn=%h f=%b c=%b exp all zero",
                     imem_req_o, imem_addr_o, instr_o, instr_pc_o, instr_valid_o,
                     pc_write_o, pc_next_o, fault_o, fault_cause_o);
        else pass_cnt++;
        resetn = 1'b1;
        step();
    endtask

    task automatic test_basic_fetch();
        start_fetch(32'h10);
        check_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10)
            $display("FAIL basic_req req=%b addr=%h exp 1/00000010", imem_req_o, imem_addr_o);
        else pass_cnt++;
        step();
        respond(32'h0050_0093, 1'b0);
        check_cnt++;
        if (instr_valid_o !== 1'b1 || instr_o !== 32'h0050_0093 || instr_pc_o !== 32'h10)
            $display("FAIL basic_instr v=%b instr=%h pc=%h exp 1/00500093/00000010",
                     instr_valid_o, instr_o, instr_pc_o);
        else pass_cnt++;
        check_cnt++;
        if (pc_write_o !== 1'b1 || pc_next_o !== 32'h14 || imem_req_o !== 1'b0)
            $display("FAIL basic_pcw pcw=%b pcn=%h req=%b exp 1/00000014/0", pc_write_o, pc_next_o, imem_req_o);
        else pass_cnt++;
    endtask

    task automatic test_hold_back_to_back();
        for (int i = 0; i < 3; i++) begin
            step();
            check_cnt++;
            if (instr_valid_o !== 1'b1 || instr_o !== 32'h0050_0093 || pc_write_o !== 1'b0)
                $display("FAIL hold_stable v=%b instr=%h pcw=%b exp 1/00500093/0",
                         instr_valid_o, instr_o, pc_write_o);
            else pass_cnt++;
        end
        instr_ready_i = 1'b1;
        start_fetch(32'h14);
        instr_ready_i = 1'b0;
        check_cnt++;
        if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h14)
            $display("FAIL back_to_back v=%b req=%b addr=%h exp 0/1/00000014",
                     instr_valid_o, imem_req_o, imem_addr_o);
        else pass_cnt++;
        respond(32'hCAFE_0001, 1'b0);
        check_cnt++;
        if (instr_o !== 32'hCAFE_0001 || pc_next_o !== 32'h18)
            $display("FAIL back_to_back_data instr=%h pcn=%h exp cafe0001/00000018", instr_o, pc_next_o);
        else pass_cnt++;
        accept();
    endtask

    task automatic test_misaligned();
        start_fetch(32'h6);
        check_cnt++;
        if (imem_req_o !== 1'b0 || fault_o !== 1'b1 || fault_cause_o !== FC_MISALIGN || pc_write_o !== 1'b0)
            $display("FAIL misalign req=%b f=%b c=%b pcw=%b exp 0/1/01/0",
                     imem_req_o, fault_o, fault_cause_o, pc_write_o);
        else pass_cnt++;
        start_fetch(32'h8);
        check_cnt++;
        if (imem_req_o !== 1'b0 || fault_o !== 1'b1 || fault_cause_o !== FC_MISALIGN)
            $display("FAIL fault_sticky req=%b f=%b c=%b exp 0/1/01", imem_req_o, fault_o, fault_cause_o);
        else pass_cnt++;
        pulse_clear();
        check_cnt++;
        if (fault_o !== 1'b0 || fault_cause_o !== FC_NONE)
            $display("FAIL fault_clear f=%b c=%b exp 0/00", fault_o, fault_cause_o);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        start_fetch(32'h40);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check_cnt++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40)
            $display("FAIL flush_req_held req=%b addr=%h exp 1/00000040", imem_req_o, imem_addr_o);
        else pass_cnt++;
        step();
        respond(32'hDEAD_BEEF, 1'b0);
        check_cnt++;
        if (instr_valid_o !== 1'b0 || pc_write_o !== 1'b0 || imem_req_o !== 1'b0)
            $display("FAIL flush_drop v=%b pcw=%b req=%b exp 0/0/0", instr_valid_o, pc_write_o, imem_req_o);
        else pass_cnt++;
        start_fetch(32'h20);
        respond(32'h1234_5678, 1'b0);
        check_cnt++;
        if (instr_valid_o !== 1'b1 || instr_o !== 32'h1234_5678 || instr_pc_o !== 32'h20 || pc_next_o !== 32'h24)
            $display("FAIL after_flush v=%b instr=%h pc=%h pcn=%h exp 1/12345678/00000020/00000024",
                     instr_valid_o, instr_o, instr_pc_o, pc_next_o);
        else pass_cnt++;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check_cnt++;
        if (instr_valid_o !== 1'b0)
            $display("FAIL hold_flush v=%b exp 0", instr_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_bus_error();
        start_fetch(32'h100);
        respond(32'h0, 1'b1);
        check_cnt++;
        if (fault_o !== 1'b1 || fault_cause_o !== FC_BUSERR || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0)
            $display("FAIL bus_error f=%b c=%b req=%b v=%b exp 1/10/0/0",
                     fault_o, fault_cause_o, imem_req_o, instr_valid_o);
        else pass_cnt++;
        pulse_clear();
    endtask

    task automatic test_timeout();
        start_fetch(32'h200);
        repeat (3) step();
        check_cnt++;
        if (fault_o !== 1'b0 || imem_req_o !== 1'b1)
            $display("FAIL timeout_early f=%b req=%b exp 0/1", fault_o, imem_req_o);
        else pass_cnt++;
        step();
        check_cnt++;
        if (fault_o !== 1'b1 || fault_cause_o !== FC_TIMEOUT || imem_req_o !== 1'b0)
            $display("FAIL timeout f=%b c=%b req=%b exp 1/11/0", fault_o, fault_cause_o, imem_req_o);
        else pass_cnt++;
        pulse_clear();
    endtask

    task automatic test_wrap();
        start_fetch(32'hFFFF_FFFC);
        respond(32'h0000_0013, 1'b0);
        check_cnt++;
        if (pc_next_o !== 32'h0 || instr_pc_o !== 32'hFFFF_FFFC || pc_write_o !== 1'b1)
            $display("FAIL pc_wrap pcn=%h ipc=%h pcw=%b exp 00000000/fffffffc/1",
                     pc_next_o, instr_pc_o, pc_write_o);
        else pass_cnt++;
        accept();
    endtask

    task automatic test_reset_mid_wait();
        start_fetch(32'h300);
        resetn = 1'b0;
        step();
        check_cnt++;
        if ({imem_req_o, imem_addr_o, instr_o, instr_pc_o, instr_valid_o, pc_write_o,
             pc_next_o, fault_o, fault_cause_o} !== '0)
            $display("FAIL reset_mid_wait req=%b addr=%h v=%b pcw=%b pcn=%h f=%b exp all zero",
                     imem_req_o, imem_addr_o, instr_valid_o, pc_write_o, pc_next_o, fault_o);
        else pass_cnt++;
        resetn = 1'b1;
        respond(32'hBAD0_BAD0, 1'b0);
        check_cnt++;
        if (instr_valid_o !== 1'b0 || pc_write_o !== 1'b0 || imem_req_o !== 1'b0 || instr_o !== 32'h0)
            $display("FAIL late_rvalid v=%b pcw=%b req=%b instr=%h exp 0/0/0/0",
                     instr_valid_o, pc_write_o, imem_req_o, instr_o);
        else pass_cnt++;
    endtask

    // Each iteration picks a transaction shape, derives its outcome from the
    // fetch rules, and checks what the DUT presents.
    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            logic [31:0] pc, word, got;
            bit mis, err, silent, dropped;
            int lat, flush_at, hold;
            mis = ($urandom_range(0, 5) == 0);
            pc = $urandom;
            if (!mis) pc[1:0] = 2'b00;
            else if (pc[1:0] == 2'b00) pc[0] = 1'b1;
            word = $urandom;
            err = ($urandom_range(0, 7) == 0);
            silent = ($urandom_range(0, 9) == 0);
            lat = $urandom_range(0, 3);
            flush_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, lat) : -1;
            hold = $urandom_range(0, 2);

            start_fetch(pc);
            if (mis) begin
                check_cnt++;
                if (fault_o !== 1'b1 || fault_cause_o !== FC_MISALIGN || imem_req_o !== 1'b0)
                    $display("FAIL rnd_misalign t=%0d f=%b c=%b req=%b exp 1/01/0",
                             t, fault_o, fault_cause_o, imem_req_o);
                else pass_cnt++;
                pulse_clear();
                continue;
            end
            check_cnt++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== pc)
                $display("FAIL rnd_req t=%0d req=%b addr=%h exp 1/%h", t, imem_req_o, imem_addr_o, pc);
            else pass_cnt++;
            if (silent) begin
                repeat (4) step();
                check_cnt++;
                if (fault_o !== 1'b1 || fault_cause_o !== FC_TIMEOUT)
                    $display("FAIL rnd_timeout t=%0d f=%b c=%b exp 1/11", t, fault_o, fault_cause_o);
                else pass_cnt++;
                pulse_clear();
                continue;
            end
            for (int c = 0; c < lat; c++) begin
                flush_i = (c == flush_at);
                step();
            end
            flush_i = (flush_at == lat);
            dropped = (flush_at >= 0);
            respond(word, err);
            flush_i = 1'b0;
            if (err) begin
                check_cnt++;
                if (fault_o !== 1'b1 || fault_cause_o !== FC_BUSERR || pc_write_o !== 1'b0)
                    $display("FAIL rnd_buserr t=%0d f=%b c=%b pcw=%b exp 1/10/0",
                             t, fault_o, fault_cause_o, pc_write_o);
                else pass_cnt++;
                pulse_clear();
            end else if (dropped) begin
                check_cnt++;
                if (instr_valid_o !== 1'b0 || pc_write_o !== 1'b0 || imem_req_o !== 1'b0)
                    $display("FAIL rnd_drop t=%0d v=%b pcw=%b req=%b exp 0/0/0",
                             t, instr_valid_o, pc_write_o, imem_req_o);
                else pass_cnt++;
            end else begin
                exp_q.push_back(word);
                check_cnt++;
                if (instr_valid_o !== 1'b1 || pc_write_o !== 1'b1 || instr_pc_o !== pc || pc_next_o !== pc + 32'd4)
                    $display("FAIL rnd_deliver t=%0d v=%b pcw=%b ipc=%h pcn=%h exp 1/1/%h/%h",
                             t, instr_valid_o, pc_write_o, instr_pc_o, pc_next_o, pc, pc + 32'd4);
                else pass_cnt++;
                repeat (hold) step();
                got = exp_q.pop_front();
                check_cnt++;
                if (instr_valid_o !== 1'b1 || instr_o !== got || pc_write_o !== (hold == 0))
                    $display("FAIL rnd_hold t=%0d v=%b instr=%h pcw=%b exp 1/%h/%0d",
                             t, instr_valid_o, instr_o, pc_write_o, got, hold == 0);
                else pass_cnt++;
                accept();
                check_cnt++;
                if (instr_valid_o !== 1'b0 || pc_write_o !== 1'b0)
                    $display("FAIL rnd_accept t=%0d v=%b pcw=%b exp 0/0", t, instr_valid_o, pc_write_o);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_hold_back_to_back();
        test_misaligned();
        test_flush();
        test_bus_error();
        test_timeout();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
